main_mem_responder: RTL
=======================

// Module: main_mem_responder
// PURPOSE
// Responder end of the main-memory valid/ready protocol driven by the memory exec element.
// Serves one write channel (main_mem_in_*) and one read channel (main_mem_out_*) from an internal
// word-organised RAM. Each request is answered with a one-cycle ready pulse after a fixed latency.
// Sits between the exec elements and the on-chip memory; one transaction in flight at a time.
// PARAMETERS
// ADDR_WIDTH  16  word-index bits; RAM depth = 2**ADDR_WIDTH 32-bit words
// LATENCY     2   cycles from request acceptance to ready pulse; legal range 1..15
// PORTS
// clk                 in   1   clock
// reset               in   1   synchronous, active-high reset
// main_mem_in_addr    in   32  write byte address
// main_mem_in_data    in   32  write data
// main_mem_in_valid   in   1   write request; held with addr/data until ready is seen
// main_mem_in_ready   out  1   one-cycle pulse: write done
// main_mem_out_addr   in   32  read byte address
// main_mem_out_valid  in   1   read request; held with addr until ready is seen
// main_mem_out_data   out  32  read data; valid in the ready cycle, held until the next read response
// main_mem_out_ready  out  1   one-cycle pulse: read data valid
// busy                out  1   high in BUSY and RESP states
// mem_err             out  1   sticky out-of-range flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; both readys=0; main_mem_out_data=0; busy=0; mem_err=0.
//   RAM contents are not cleared. A reset mid-transaction drops it: no ready pulse, no RAM write.
// - Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored. No byte enables.
// - FSM IDLE -> BUSY -> RESP -> IDLE.
//   - IDLE: accept on valid. If both valids are high, the write wins; the read stays pending
//     and is accepted in the next IDLE cycle.
//   - On acceptance, latch type, index and write data. Go to BUSY with count=LATENCY-1,
//     or straight to RESP when LATENCY=1.
//   - BUSY: decrement count each cycle; go to RESP when the count reaches 0.
//   - RESP: assert the matching ready for exactly one cycle, then return to IDLE.
// - Latency: a request accepted in cycle T (valid high while IDLE) gets ready in cycle T+LATENCY.
//   Minimum back-to-back spacing is LATENCY+1 cycles.
// - Read: main_mem_out_data is loaded from RAM[latched index] on the edge entering RESP.
// - Write: RAM[latched index] <= latched data on the edge leaving RESP.
//   A read accepted after that edge returns the new value.
// - The initiator must drop valid in the cycle after ready. Inputs are ignored outside IDLE,
//   so changes to addr/data after acceptance have no effect.
// - Both readys are never high in the same cycle.
// CONFIGURATION
// MAIN_MEM_BOUNDS_EN defined: a request with addr[31:ADDR_WIDTH+2] != 0 is out of range.
//   - It still completes with normal latency and a ready pulse.
//   - A write does not touch the RAM; a read returns 32'h0.
//   - mem_err is set on the edge entering RESP and stays set until reset.
// MAIN_MEM_BOUNDS_EN undefined: upper address bits are ignored (addresses alias modulo depth);
//   mem_err is tied to 0.
// TESTING
// 1 LATENCY=2: write addr 0x10, data 0xCAFEBABE, valid in cycle T -> in_ready=1 only in T+2;
//   then read 0x10 -> out_ready in its T'+2 with out_data=0xCAFEBABE.
// 2 LATENCY=1 and LATENCY=5: a read must pulse ready exactly 1 and 5 cycles after acceptance;
//   busy is high for 1 and 5 cycles respectively.
// 3 Both valids raised in the same cycle, addr 0x20, write data 0x12345678 -> in_ready first;
//   out_ready LATENCY+1 cycles later with out_data=0x12345678.
// 4 Write 0x13 with 0xA5A5A5A5, then read 0x10 -> out_data=0xA5A5A5A5 (low bits ignored).
// 5 ADDR_WIDTH=16, write 0x00100000 with 0xFFFFFFFF:
//   - with macro: ready pulses, mem_err=1, RAM[0] unchanged, read 0x00100000 returns 0;
//   - without macro: RAM[0]=0xFFFFFFFF, mem_err=0.
// 6 reset asserted in the BUSY cycle of a write to 0x40 -> no in_ready, RAM[0x40>>2] unchanged,
//   busy=0; the next read completes with normal latency.

Source files
------------

// File: rtl/main_mem_if.sv
// Main-memory valid/ready bundle: one write channel (in_*) and one read channel (out_*).
interface main_mem_if;
    logic [31:0] main_mem_in_addr;
    logic [31:0] main_mem_in_data;
    logic        main_mem_in_valid;
    logic        main_mem_in_ready;
    logic [31:0] main_mem_out_addr;
    logic        main_mem_out_valid;
    logic [31:0] main_mem_out_data;
    logic        main_mem_out_ready;

    modport master (
        output main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
        output main_mem_out_addr, main_mem_out_valid,
        input  main_mem_in_ready, main_mem_out_data, main_mem_out_ready
    );

    modport slave (
        input  main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
        input  main_mem_out_addr, main_mem_out_valid,
        output main_mem_in_ready, main_mem_out_data, main_mem_out_ready
    );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory responder: word RAM behind a fixed-latency, one-in-flight valid/ready FSM.
// Optional MAIN_MEM_BOUNDS_EN flags out-of-range addresses on mem_err instead of aliasing.
module main_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    main_mem_if.slave   bus,
    output logic        busy,
    output logic        mem_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  wr_q, oob_q, busy_q;
    logic                  in_ready_q, out_ready_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [31:0]           mem [DEPTH];

    logic                  acc, acc_wr, acc_oob;
    logic [31:0]           acc_addr;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  ent_resp, ent_wr, ent_oob;
    logic [ADDR_WIDTH-1:0] ent_idx;

    // Write has priority when both channels request in the same IDLE cycle.
    always_comb begin
        acc      = (state_q == IDLE) && (bus.main_mem_in_valid || bus.main_mem_out_valid);
        acc_wr   = bus.main_mem_in_valid;
        acc_addr = acc_wr ? bus.main_mem_in_addr : bus.main_mem_out_addr;
        acc_idx  = acc_addr[ADDR_WIDTH+1:2];
`ifdef MAIN_MEM_BOUNDS_EN
        acc_oob  = (acc_addr[31:ADDR_WIDTH+2] != '0);
`else
        acc_oob  = 1'b0;
`endif
    end

`ifdef MAIN_MEM_BOUNDS_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[1:0];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};
`endif

    // Transaction attributes used on the edge that enters RESP (fresh ones when LATENCY==1).
    always_comb begin
        ent_resp = 1'b0;
        ent_wr   = wr_q;
        ent_oob  = oob_q;
        ent_idx  = idx_q;
        if (acc) begin
            ent_wr   = acc_wr;
            ent_oob  = acc_oob;
            ent_idx  = acc_idx;
            ent_resp = (LATENCY == 1);
        end else if (state_q == BUSY && cnt_q == 4'd1) begin
            ent_resp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            oob_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_ready_q <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            in_ready_q  <= 1'b0;
            out_ready_q <= 1'b0;
            if (ent_resp) begin
                in_ready_q  <= ent_wr;
                out_ready_q <= !ent_wr;
                if (!ent_wr) rdata_q <= ent_oob ? 32'h0 : mem[ent_idx];
            end
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        wr_q    <= acc_wr;
                        oob_q   <= acc_oob;
                        idx_q   <= acc_idx;
                        wdata_q <= bus.main_mem_in_data;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (ent_resp) state_q <= RESP;
                    else          cnt_q   <= cnt_q - 4'd1;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Commit happens on the edge leaving RESP; a reset in that cycle cancels it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && wr_q && !oob_q) mem[idx_q] <= wdata_q;
    end

`ifdef MAIN_MEM_BOUNDS_EN
    logic mem_err_q;
    always_ff @(posedge clk) begin
        if (reset)                   mem_err_q <= 1'b0;
        else if (ent_resp && ent_oob) mem_err_q <= 1'b1;
    end
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign bus.main_mem_in_ready  = in_ready_q;
    assign bus.main_mem_out_ready = out_ready_q;
    assign bus.main_mem_out_data  = rdata_q;
    assign busy                   = busy_q;
endmodule
